// File: rtl/ram_pkg.sv
// Shared types and default geometry for the self-clearing synchronous RAM.
package ram_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;
endpackage

// File: rtl/ram_sync_core.sv
// Plain storage array: one write port and one registered read port, no reset, so it maps onto block RAM.
module ram_sync_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/ram_sync_clr.sv
// Synchronous RAM with a clear engine that sweeps CLR_VALUE through every word after reset or on request.
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int          DATA_W    = DEF_DATA_W,
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter logic [63:0] CLR_VALUE = 64'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              select,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              ready,
    output logic              busy
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LAST     = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [DATA_W-1:0] CLR_WORD = CLR_VALUE[DATA_W-1:0];

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              acc, we, re, zeroed;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata, q;

    // rst_n is expected to be released synchronously to clk by the reset source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (clear)            cnt_nxt   = '0;
                else if (cnt == LAST) state_nxt = IDLE;
            end
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // A clear request wins over a user access presented in the same cycle
    always_comb begin
        busy  = (state == CLEAR);
        ready = (state == IDLE);
        acc   = ready & select & ~clear;
        we    = busy | (acc & write);
        re    = acc & ~write;
        waddr = busy ? cnt[ADDR_W-1:0] : address;
        wdata = busy ? CLR_WORD : data_in;
    end

    // zeroed masks the unreset core output until the first read after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            zeroed   <= 1'b1;
        end else begin
            rd_valid <= re;
            if (re) zeroed <= 1'b0;
        end
    end

    assign data_out = zeroed ? '0 : q;

    ram_sync_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (address),
        .q     (q)
    );
endmodule

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 10, address width; depth = 2**ADDR_W words.
REQ-003 Parameter CLR_VALUE, default 0, word value written by the clear engine (truncated to DATA_W).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low, synchronous release.
REQ-006 select  input  1  access request; sampled only when ready=1.
REQ-007 write  input  1  1 = write, 0 = read; qualifies select.
REQ-008 address  input  ADDR_W  word address of the access.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 clear  input  1  single-cycle pulse requesting a full-array clear.
REQ-011 data_out  output  DATA_W  registered read data.
REQ-012 rd_valid  output  1  one-cycle strobe, data_out holds the requested word.
REQ-013 ready  output  1  block accepts select this cycle.
REQ-014 busy  output  1  clear engine active.

Function
REQ-015 FSM states: CLEAR and IDLE only, encoded in the shared package.
REQ-016 Reset deassertion enters CLEAR with clear counter = 0.
REQ-017 CLEAR writes CLR_VALUE to address = counter each cycle, counter +1 per cycle.
REQ-018 CLEAR -> IDLE in the cycle after counter = 2**ADDR_W-1 is written; total 2**ADDR_W cycles.
REQ-019 busy = 1 and ready = 0 exactly while in CLEAR.
REQ-020 IDLE + clear = 1 -> CLEAR, counter reset to 0; select in that same cycle is ignored.
REQ-021 clear while already in CLEAR restarts counter at 0.
REQ-022 Accepted write (ready & select & write): mem[address] <= data_in at that edge; no rd_valid.
REQ-023 Accepted read (ready & select & ~write): data_out = mem[address] and rd_valid = 1 one cycle later; latency exactly 1.
REQ-024 Back-to-back reads every cycle are supported; one rd_valid per accepted read, in order.
REQ-025 Read after write to same address on the next cycle returns the new data.
REQ-026 data_out holds its last value when rd_valid = 0.
REQ-027 select during CLEAR is dropped: no write, no rd_valid.
REQ-028 Address arithmetic of the clear counter is ADDR_W+1 bits; no wrap into address 0 before exit.

Reset
REQ-029 rst_n = 0 forces immediately: state CLEAR, counter 0, data_out 0, rd_valid 0, ready 0, busy 1.
REQ-030 Reset mid-clear or mid-read discards any pending rd_valid; clear restarts from address 0.
REQ-031 Memory array is not reset directly; zeroing is done only by the clear engine.

Structure
REQ-032 Package ram_pkg holds state typedef (CLEAR, IDLE) and default DATA_W/ADDR_W constants.
REQ-033 Storage is sub-module ram_sync_core: one write port, one registered read port, no reset, inferable as block RAM.
REQ-034 FSM, counter and write-port mux (clear vs user) live in ram_sync_clr.

Verification
REQ-035 Reset release -> busy=1 for 1024 cycles, then ready=1; reads of addresses 0, 511, 1023 return 0.
REQ-036 Write data (2k)%256 to k=0..1023, read all back -> each rd_valid shows (2k)%256, latency 1.
REQ-037 Write 0xA5 @ 7, read 7 next cycle -> data_out 0xA5, rd_valid one cycle after acceptance.
REQ-038 Pulse clear after loading data, select asserted same cycle -> select ignored, 1024 busy cycles, address 300 reads 0.
REQ-039 Assert rst_n=0 at clear counter 500 -> outputs reset immediately; after release full 1024-cycle clear repeats.
REQ-040 DATA_W=16, ADDR_W=4 instance -> 16-cycle clear, write 0xBEEF @ 15, read returns 0xBEEF.
